// File: rtl/retire_trace_fifo_pkg.sv
// Shared types and constants for the retire trace buffer.
// Optional timestamping is enabled by defining RETIRE_TRACE_TIMESTAMP_EN.
package retire_trace_fifo_pkg;

    localparam int unsigned RT_ADDR_WIDTH        = 32;
    localparam int unsigned RT_DATA_WIDTH        = 32;
    localparam int unsigned RT_INSTR_WIDTH       = 32;
    localparam int unsigned RT_REG_ADDR_WIDTH    = 5;
    localparam int unsigned RT_DMEM_OP_WIDTH     = 3;
    localparam int unsigned RT_DROP_CNT_WIDTH    = 16;
    localparam int unsigned RT_TS_WIDTH          = 32;
    localparam int unsigned RETIRE_DEPTH_DEFAULT = 8;

    // One committed instruction as seen by the reference-model checker
    typedef struct packed {
        logic [RT_ADDR_WIDTH-1:0]     pc;
        logic [RT_INSTR_WIDTH-1:0]    instr;
        logic                         rd_we;
        logic [RT_REG_ADDR_WIDTH-1:0] rd_addr;
        logic [RT_DATA_WIDTH-1:0]     rd_data;
        logic [RT_DMEM_OP_WIDTH-1:0]  dmem_op;
        logic                         dmem_we;
        logic [RT_ADDR_WIDTH-1:0]     dmem_addr;
        logic [RT_DATA_WIDTH-1:0]     dmem_data;
    } retire_rec_t;

    localparam int unsigned RETIRE_REC_WIDTH = $bits(retire_rec_t);

    // Record width implied by a set of field widths; equals RETIRE_REC_WIDTH
    // when the module parameters agree with the package defaults.
    function automatic int unsigned rec_width(input int unsigned aw,
                                              input int unsigned dw,
                                              input int unsigned iw,
                                              input int unsigned rw);
        return 2 * aw + 2 * dw + iw + rw + RT_DMEM_OP_WIDTH + 2;
    endfunction

endpackage

// File: rtl/retire_trace_fifo_if.sv
// Retire capture and drain handshake bundle for retire_trace_fifo.
// out_ts_o exists only when RETIRE_TRACE_TIMESTAMP_EN is defined.
interface retire_trace_fifo_if;
    import retire_trace_fifo_pkg::*;

    logic        ret_valid_i;
    retire_rec_t ret_rec_i;
    logic        out_valid_o;
    logic        out_ready_i;
    retire_rec_t out_rec_o;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [RT_TS_WIDTH-1:0] out_ts_o;

    modport slave (
        input  ret_valid_i, ret_rec_i, out_ready_i,
        output out_valid_o, out_rec_o, out_ts_o
    );
    modport master (
        output ret_valid_i, ret_rec_i, out_ready_i,
        input  out_valid_o, out_rec_o, out_ts_o
    );
`else
    modport slave (
        input  ret_valid_i, ret_rec_i, out_ready_i,
        output out_valid_o, out_rec_o
    );
    modport master (
        output ret_valid_i, ret_rec_i, out_ready_i,
        input  out_valid_o, out_rec_o
    );
`endif

endinterface

// File: rtl/retire_trace_fifo_mem.sv
// Record storage: DEPTH x WIDTH register array, one write port and one
// asynchronous read port. Contents are never reset.
module retire_trace_mem #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Write the incoming record into its slot
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Head read is combinational so a pushed record is visible next cycle
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/retire_trace_fifo.sv
// Retire commit-trace FIFO: captures one retire record per cycle and lets a
// checker drain them over valid/ready. Drops on full are counted and flagged.
// DEPTH must be a power of two and at least 2; the width parameters must match
// the field widths of retire_rec_t in retire_trace_fifo_pkg.
// Define RETIRE_TRACE_TIMESTAMP_EN to stamp each record with a cycle counter.
module retire_trace_fifo
    import retire_trace_fifo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = retire_trace_fifo_pkg::RT_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned DEPTH          = 8,
    parameter int unsigned DROP_CNT_WIDTH = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    retire_trace_fifo_if.slave         trace_if,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o,
    output logic                       overflow_o,
    output logic [DROP_CNT_WIDTH-1:0]  drop_cnt_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned REC_W = rec_width(ADDR_WIDTH, DATA_WIDTH, INSTR_WIDTH, REG_ADDR_WIDTH);
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    localparam int unsigned WORD_W = REC_W + RT_TS_WIDTH;
`else
    localparam int unsigned WORD_W = REC_W;
`endif

    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]          count_q, count_d;
    logic                      full_q, full_d;
    logic                      out_valid_q, out_valid_d;
    logic                      overflow_q, overflow_d;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

    logic                      pop_c;
    logic                      push_c;
    logic                      drop_c;
    logic                      mem_we_c;
    logic [WORD_W-1:0]         mem_wdata_c;
    logic [WORD_W-1:0]         mem_rdata_c;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [RT_TS_WIDTH-1:0]    ts_q;

    // Free-running cycle counter; only reset clears it, flush does not
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + RT_TS_WIDTH'(1);
        end
    end

    assign mem_wdata_c       = {ts_q, REC_W'(trace_if.ret_rec_i)};
    assign trace_if.out_ts_o = mem_rdata_c[WORD_W-1:REC_W];
`else
    assign mem_wdata_c = REC_W'(trace_if.ret_rec_i);
`endif

    // Handshake decode: a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        pop_c  = out_valid_q && trace_if.out_ready_i;
        push_c = trace_if.ret_valid_i && (!full_q || pop_c);
        drop_c = trace_if.ret_valid_i && full_q && !pop_c;
    end

    // Next-state for pointers, occupancy and drop bookkeeping; flush wins
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (flush_i) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (push_c) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
            if (drop_c) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
                end
            end
        end
        full_d      = (count_d == CNT_W'(DEPTH));
        out_valid_d = (count_d != '0);
    end

    // State registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            out_valid_q <= out_valid_d;
            overflow_q  <= overflow_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign mem_we_c = push_c && !flush_i && !rst_i;

    retire_trace_mem #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (mem_we_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (mem_wdata_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (mem_rdata_c)
    );

    assign trace_if.out_valid_o = out_valid_q;
    assign trace_if.out_rec_o   = retire_rec_t'(RETIRE_REC_WIDTH'(mem_rdata_c[REC_W-1:0]));
    assign count_o              = count_q;
    assign full_o               = full_q;
    assign overflow_o           = overflow_q;
    assign drop_cnt_o           = drop_cnt_q;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Bench for retire_trace_fifo (DEPTH=4, DROP_CNT_WIDTH=2). Records accepted by
// the stimulus are queued; a negedge monitor checks every popped head record.
module tb_retire_trace_fifo;
    import retire_trace_fifo_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned DCW   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [2:0]       count;
    logic             full;
    logic             overflow;
    logic [DCW-1:0]   drop_cnt;

    int               n_vec = 0;
    int               n_err = 0;
    int               m_cnt = 0;
    retire_rec_t      exp_q[$];
    retire_rec_t      mon_exp;

    always #5 clk = ~clk;

    retire_trace_fifo_if tif ();

    retire_trace_fifo #(
        .DEPTH          (DEPTH),
        .DROP_CNT_WIDTH (DCW)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .flush_i    (flush),
        .trace_if   (tif),
        .count_o    (count),
        .full_o     (full),
        .overflow_o (overflow),
        .drop_cnt_o (drop_cnt)
    );

    function automatic retire_rec_t mk(input logic [31:0] pc);
        retire_rec_t r;
        r.pc        = pc;
        r.instr     = 32'hA500_0013 ^ (pc << 8);
        r.rd_we     = pc[2];
        r.rd_addr   = pc[6:2];
        r.rd_data   = ~pc;
        r.dmem_op   = pc[4:2];
        r.dmem_we   = pc[3];
        r.dmem_addr = pc + 32'h0000_1000;
        r.dmem_data = pc * 32'd3;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One cycle of stimulus; expected records are queued when acceptance is due
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy);
        bit pop;
        bit acc;
        tif.ret_valid_i = v;
        tif.ret_rec_i   = mk(pc);
        tif.out_ready_i = rdy;
        pop = (m_cnt != 0) && rdy;
        acc = v && ((m_cnt < int'(DEPTH)) || pop);
        if (acc) exp_q.push_back(mk(pc));
        m_cnt = m_cnt + int'(acc) - int'(pop);
        @(posedge clk);
        #1;
        tif.ret_valid_i = 1'b0;
        tif.out_ready_i = 1'b0;
    endtask

    // Monitor: every head consumed by the checker must match the queue front
    always @(negedge clk) begin
        if (!rst && !flush && tif.out_valid_o && tif.out_ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL pop_unexpected: got pc %0h expected no record", tif.out_rec_o.pc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (tif.out_rec_o !== mon_exp) begin
                    n_err++;
                    $display("FAIL rec: got pc %0h instr %0h rd_data %0h expected pc %0h instr %0h rd_data %0h",
                             tif.out_rec_o.pc, tif.out_rec_o.instr, tif.out_rec_o.rd_data,
                             mon_exp.pc, mon_exp.instr, mon_exp.rd_data);
                end
            end
        end
    end

    initial begin
        rst             = 1'b1;
        flush           = 1'b0;
        tif.ret_valid_i = 1'b0;
        tif.ret_rec_i   = mk(32'h0);
        tif.out_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_count", count, 0);
        chk("rst_valid", tif.out_valid_o, 0);
        chk("rst_full", full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_drop", drop_cnt, 0);

        // Three pushes with the checker stalled
        step(1, 32'h00, 0);
        step(1, 32'h04, 0);
        step(1, 32'h08, 0);
        chk("p3_count", count, 3);
        chk("p3_full", full, 0);
        chk("p3_valid", tif.out_valid_o, 1);
        chk("p3_head", tif.out_rec_o.pc, 32'h00);

        // Fill, then a dropped push
        step(1, 32'h0C, 0);
        chk("fill_count", count, 4);
        chk("fill_full", full, 1);
        step(1, 32'h10, 0);
        chk("drop_overflow", overflow, 1);
        chk("drop_cnt1", drop_cnt, 1);
        chk("drop_count", count, 4);
        chk("drop_head", tif.out_rec_o.pc, 32'h00);

        // Push and pop together while full
        step(1, 32'h20, 1);
        chk("pp_count", count, 4);
        chk("pp_full", full, 1);
        chk("pp_overflow", overflow, 1);
        repeat (4) step(0, 32'h0, 1);
        chk("drain_count", count, 0);
        chk("drain_valid", tif.out_valid_o, 0);
        chk("drain_overflow", overflow, 1);
        chk("drain_drop", drop_cnt, 1);

        // Ten push/pop pairs, pointers wrap
        for (int i = 0; i < 10; i++) begin
            step(1, 32'h100 + 32'(4 * i), 1);
            chk("pair_count_push", count, 1);
            step(0, 32'h0, 1);
            chk("pair_count_pop", count, 0);
        end

        // Flush with a simultaneous retire
        step(1, 32'h200, 0);
        step(1, 32'h204, 0);
        step(1, 32'h208, 0);
        chk("pre_flush_count", count, 3);
        flush           = 1'b1;
        tif.ret_valid_i = 1'b1;
        tif.ret_rec_i   = mk(32'h300);
        @(posedge clk);
        #1;
        flush           = 1'b0;
        tif.ret_valid_i = 1'b0;
        m_cnt           = 0;
        exp_q.delete();
        chk("flush_count", count, 0);
        chk("flush_valid", tif.out_valid_o, 0);
        chk("flush_overflow", overflow, 0);
        chk("flush_drop", drop_cnt, 0);
        chk("flush_full", full, 0);

        // Drop counter saturation
        for (int i = 0; i < 4; i++) step(1, 32'h400 + 32'(4 * i), 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h500 + 32'(4 * i), 0);
            chk("sat_drop", drop_cnt, (i < 2) ? 64'(i + 1) : 64'd3);
        end
        chk("sat_overflow", overflow, 1);
        chk("sat_count", count, 4);
        repeat (4) step(0, 32'h0, 1);
        chk("sat_drain_count", count, 0);

        // Reset overrides a same-cycle push
        step(1, 32'h600, 0);
        step(1, 32'h604, 0);
        rst             = 1'b1;
        tif.ret_valid_i = 1'b1;
        tif.ret_rec_i   = mk(32'h608);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        tif.ret_valid_i = 1'b0;
        m_cnt           = 0;
        exp_q.delete();
        chk("rstpush_count", count, 0);
        chk("rstpush_valid", tif.out_valid_o, 0);
        chk("rstpush_drop", drop_cnt, 0);

`ifdef RETIRE_TRACE_TIMESTAMP_EN
        // Push in cycle 7 after reset carries timestamp 7
        repeat (7) step(0, 32'h0, 0);
        step(1, 32'h700, 0);
        chk("ts_value", tif.out_ts_o, 7);
        step(0, 32'h0, 1);
`endif

        chk("sb_empty", 64'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Parametrised RTL commit-trace buffer for the simple processor verification environment.
- Captures one retire record per cycle: PC, instruction, GPR write, and data-memory op/we/addr/data.
- Holds records in a circular FIFO.
- A valid/ready drain port lets the checker pop one record per step of the C reference model and compare field by field.
- Adds overflow detection, a saturating drop counter and flush, which the per-step model interface lacks.

Parameters:
- ADDR_WIDTH, default simple_processor_pkg::ADDR_WIDTH: PC and dmem address width.
- DATA_WIDTH, default 32: GPR and dmem data width.
- INSTR_WIDTH, default 32: instruction word width.
- REG_ADDR_WIDTH, default 5: GPR index width.
- DEPTH, default 8: record slots; power of two, ≥2.
- DROP_CNT_WIDTH, default 16: drop counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  discard all stored records.
- ret_valid_i  in  1  retire record present this cycle.
- ret_rec_i  in  $bits(retire_rec_t)  packed retire record.
- out_valid_o  out  1  head record available.
- out_ready_i  in  1  checker consumes head.
- out_rec_o  out  $bits(retire_rec_t)  head record.
- count_o  out  $clog2(DEPTH)+1  occupancy.
- full_o  out  1  count_o == DEPTH.
- overflow_o  out  1  sticky: a record was dropped.
- drop_cnt_o  out  DROP_CNT_WIDTH  records dropped, saturating.

Behaviour:
- Reset (rst_i high at clk edge):
  - wr_ptr, rd_ptr, count_o, overflow_o and drop_cnt_o go to 0.
  - out_valid_o=0, full_o=0.
  - out_rec_o is don't-care while out_valid_o=0; storage is not cleared.
  - Reset overrides flush, push and pop in the same cycle.
- Push: ret_valid_i && (!full_o || pop).
  - mem[wr_ptr] <= ret_rec_i; wr_ptr increments modulo DEPTH.
- Pop: out_valid_o && out_ready_i.
  - rd_ptr increments modulo DEPTH.
- out_valid_o = (count_o != 0). out_rec_o = mem[rd_ptr], combinational read of the head.
- Latency: a record pushed at edge N is visible on out_rec_o after edge N (1 cycle).
  - An empty FIFO has no bypass: a same-cycle push and pop on an empty FIFO is impossible because out_valid_o=0.
- Count: count_o += push - pop.
  - Push+pop on full is legal: count stays DEPTH and the record is accepted.
  - Push+pop on non-empty: count unchanged.
- Drop: ret_valid_i && full_o && !pop.
  - Record discarded, overflow_o <= 1.
  - drop_cnt_o increments, saturating at all-ones with no wrap.
  - FIFO contents and pointers unchanged.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally. full/empty derive from count_o, not pointer compare.
- Flush (flush_i high, rst_i low):
  - Pointers, count, overflow_o and drop_cnt_o go to 0.
  - A simultaneous push or pop is ignored; flush wins.
- Pop when empty has no effect. out_ready_i is a don't-care when out_valid_o=0.
- No internal state machine beyond the pointer/count datapath. The effective states are EMPTY / PARTIAL / FULL, all derived from count_o.

Optional Feature:
- Macro: RETIRE_TRACE_TIMESTAMP_EN.
- Defined:
  - Adds a TS_WIDTH=32 free-running cycle counter, reset to 0, incrementing every non-reset cycle and wrapping at 2^32.
  - Each pushed record stores the counter value of its push cycle.
  - Extra output port out_ts_o (out, 32) gives the head record's timestamp.
  - Flush does not reset the counter.
- Undefined: no counter, no timestamp storage, and port out_ts_o is absent.

Decomposition:
- Put in simple_processor_pkg (or the verification package next to the model DPI imports):
  - retire_rec_t packed struct, fields: pc, instr, rd_we, rd_addr, rd_data, dmem_op, dmem_we, dmem_addr, dmem_data.
  - RETIRE_DEPTH_DEFAULT constant.
- One natural sub-module: retire_trace_mem, a DEPTH×$bits(retire_rec_t) register array with one write port and one asynchronous read port. The pointer/count logic stays in the top.

Test Plan (DEPTH=4):
- Reset → push PC 0x00,0x04,0x08 with out_ready_i=0 → count_o=3, out_rec_o.pc=0x00, full_o=0.
- Fill to 4, push PC 0x10 with no pop → full_o=1, overflow_o=1, drop_cnt_o=1; drain order 0x00,0x04,0x08,0x0C.
- Full FIFO, push 0x20 and pop in same cycle → count_o stays 4; after draining, last record pc=0x20; overflow_o unchanged.
- 10 push/pop pairs with a 1-cycle gap → pointers wrap twice; records emerge in order with instr/rd_data intact, count_o never exceeds 1.
- count_o=3, overflow_o=1, flush_i with ret_valid_i=1 → next cycle count_o=0, out_valid_o=0, overflow_o=0, drop_cnt_o=0.
- DROP_CNT_WIDTH=2, full FIFO, 5 dropped pushes → drop_cnt_o=3 (saturated). With RETIRE_TRACE_TIMESTAMP_EN: push at cycle 7 after reset → out_ts_o=7.
